// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shift register with a valid/ready
// load handshake, per-bit shift enable, selectable bit order and a
// frame-done pulse. Back-to-back frames are accepted on the final bit.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends an even-parity
// bit (XOR of the loaded word) after the data bits of every frame.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   sreg_shift;
    logic [CNT_W-1:0]   cnt;
    logic               fin_c;
    logic               consume_fin;
    logic               accept;
    logic               load_first;
    logic               shift_first;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic               parity_bit;
`endif

    // Final bit of the frame is currently being presented
`ifdef PISO_SERIALIZER_PARITY_EN
    assign fin_c = (state == ST_PARITY);
`else
    assign fin_c = (state == ST_SHIFT) && (cnt == '0);
`endif

    assign consume_fin = fin_c && shift_en;
    assign load_ready  = rst_n && ((state == ST_IDLE) || consume_fin);
    assign accept      = load_valid && load_ready;

    // Shift toward the output end with zero fill, and pick the bit that
    // will be presented next for a fresh word or a shifted register
    always_comb begin
        sreg_shift  = '0;
        load_first  = 1'b0;
        shift_first = 1'b0;
        if (MSB_FIRST) begin
            sreg_shift  = {sreg[WIDTH-2:0], 1'b0};
            load_first  = load_data[WIDTH-1];
            shift_first = sreg[WIDTH-2];
        end else begin
            sreg_shift  = {1'b0, sreg[WIDTH-1:1]};
            load_first  = load_data[0];
            shift_first = sreg[1];
        end
    end

    // Frame FSM with registered serial outputs and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= consume_fin;
            if (accept) begin
                state     <= ST_SHIFT;
                sreg      <= load_data;
                cnt       <= CNT_W'(WIDTH - 1);
                ser_valid <= 1'b1;
                ser_out   <= load_first;
`ifdef PISO_SERIALIZER_PARITY_EN
                parity_bit <= ^load_data;
`endif
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (shift_en) begin
                            if (cnt == '0) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                                state   <= ST_PARITY;
                                ser_out <= parity_bit;
`else
                                state     <= ST_IDLE;
                                ser_valid <= 1'b0;
                                ser_out   <= 1'b0;
`endif
                            end else begin
                                sreg    <= sreg_shift;
                                cnt     <= cnt - CNT_W'(1);
                                ser_out <= shift_first;
                            end
                        end
                    end
`ifdef PISO_SERIALIZER_PARITY_EN
                    ST_PARITY: begin
                        if (shift_en) begin
                            state     <= ST_IDLE;
                            ser_valid <= 1'b0;
                            ser_out   <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first and MSB-first instances share stimulus
// and are compared each cycle against a bit-queue frame model.
module tb_piso_serializer;

    localparam int unsigned WIDTH = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int unsigned FLEN = WIDTH + 1;
`else
    localparam int unsigned FLEN = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic             lr0, so0, sv0, dn0;
    logic             lr1, so1, sv1, dn1;

    // Reference state: remaining bits of the frame in presentation order
    bit q0[$];
    bit q1[$];
    bit cap_q[$];
    bit done_m;

    int n_pass;
    int n_total;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr0),
        .load_data(load_data), .shift_en(shift_en), .ser_out(so0),
        .ser_valid(sv0), .done(dn0)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr1),
        .load_data(load_data), .shift_en(shift_en), .ser_out(so1),
        .ser_valid(sv1), .done(dn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic load_frame(input logic [WIDTH-1:0] d);
        q0.delete();
        q1.delete();
        for (int i = 0; i < int'(WIDTH); i++) begin
            q0.push_back(d[i]);
            q1.push_back(d[int'(WIDTH) - 1 - i]);
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        q0.push_back(^d);
        q1.push_back(^d);
`endif
    endtask

    // One clock cycle: drive, check outputs, advance model, wait for edge
    task automatic step(input bit lv, input logic [WIDTH-1:0] ld, input bit se);
        bit rdy;
        bit fin;
        load_valid = lv;
        load_data  = ld;
        shift_en   = se;
        #1;
        rdy = (q0.size() == 0) || ((q0.size() == 1) && se);
        check("load_ready_lsb", 32'(lr0), 32'(rdy));
        check("load_ready_msb", 32'(lr1), 32'(rdy));
        check("ser_valid_lsb", 32'(sv0), 32'(q0.size() != 0));
        check("ser_valid_msb", 32'(sv1), 32'(q1.size() != 0));
        check("ser_out_lsb", 32'(so0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
        check("ser_out_msb", 32'(so1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
        check("done_lsb", 32'(dn0), 32'(done_m));
        check("done_msb", 32'(dn1), 32'(done_m));
        if (sv0 && se) cap_q.push_back(so0);
        fin = (q0.size() == 1) && se;
        if (se && (q0.size() != 0)) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        if (lv && rdy) load_frame(ld);
        done_m = fin;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < int'(FLEN) + 2; i++) step(1'b0, '0, 1'b1);
    endtask

    task automatic check_capture(input string tag, input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < int'(WIDTH); i++)
            if (i < cap_q.size()) w[i] = cap_q[i];
        check({tag, "_len"}, 32'(cap_q.size()), 32'(FLEN));
        check({tag, "_word"}, 32'(w), 32'(exp));
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        done_m     = 1'b0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b0;
        #2;
        check("rst_load_ready", 32'(lr0), 32'd0);
        check("rst_ser_valid", 32'(sv0), 32'd0);
        check("rst_ser_out", 32'(so0), 32'd0);
        check("rst_done", 32'(dn0), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic frame, continuous shifting
        cap_q.delete();
        step(1'b1, 8'h1E, 1'b0);
        drain();
        check_capture("frame_1e", 8'h1E);

        // Stall after two consumed bits
        cap_q.delete();
        step(1'b1, 8'h1E, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        drain();
        check_capture("stall_1e", 8'h1E);

        // Back-to-back: second word offered during the final bit
        step(1'b1, 8'h1E, 1'b0);
        for (int i = 0; i < int'(FLEN) - 1; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 8'h81, 1'b1);
        check("b2b_valid", 32'(sv0), 32'd1);
        check("b2b_first_bit", 32'(so0), 32'd1);
        check("b2b_done", 32'(dn0), 32'd1);
        drain();

        // Parity-carrying word (odd ones count)
        step(1'b1, 8'h07, 1'b0);
        drain();

        // Busy rejection then asynchronous reset mid-frame
        step(1'b1, 8'h1E, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ser_valid", 32'(sv0), 32'd0);
        check("arst_ser_out", 32'(so0), 32'd0);
        check("arst_done", 32'(dn0), 32'd0);
        check("arst_load_ready", 32'(lr0), 32'd0);
        q0.delete();
        q1.delete();
        done_m = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("arst_hold_done", 32'(dn0), 32'd0);
        rst_n = 1'b1;
        cap_q.delete();
        step(1'b1, 8'h1E, 1'b0);
        drain();
        check_capture("post_rst_1e", 8'h1E);

        // Randomised traffic
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 3) != 0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
